// File: rtl/user_pkg.sv
// user_pkg: shared definitions for the SPI TX stream block.
//   - register offsets (word index, decoded from addr[4:2])
//   - FIFO entry layout {last, dc, data}
//   - serializer FSM state encoding
//   - reset value of the SCK half-period divider
package user_pkg;

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CLKDIV = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;
    localparam logic [2:0] OFF_RXDATA = 3'd4;

    localparam int CLKDIV_RST = 3;

    typedef struct packed {
        logic       last;
        logic       dc;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/user_spi_tx_fifo.sv
// user_spi_tx_fifo: synchronous FIFO of SPI TX entries.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_flush        : empty the FIFO (wins over push/pop)
//   i_push/i_wdata : write an entry, ignored when full
//   i_pop/o_rdata  : head entry (show-ahead), pop ignored when empty
//   o_full, o_empty, o_level : occupancy
module user_spi_tx_fifo
    import user_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  entry_t                   i_wdata,
    input  logic                     i_pop,
    output entry_t                   o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(Depth):0]   o_level
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(Depth);

    entry_t          r_mem [Depth];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leave the level unchanged.
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/user_spi_tx_stream.sv
// user_spi_tx_stream: OBI subordinate feeding a TX FIFO that is streamed out
// as SPI mode 0 (MSB first) with per-byte DC and frame-level chip select.
// Optional build macro: USER_SPI_TX_RX_EN adds miso_i and RXDATA (0x10).
// Ports:
//   clk_i, rst_ni                      : clock, synchronous active-low reset
//   req_i/we_i/be_i/addr_i/wdata_i/aid_i : OBI request (be_i ignored)
//   gnt_o/rvalid_o/rdata_o/rid_o/err_o : OBI grant and response
//   sck_o, mosi_o, dc_o, cs_no         : SPI / OLED lines
//   irq_o                              : level interrupt (idle and empty)
module user_spi_tx_stream
    import user_pkg::*;
#(
    parameter int FifoDepth   = 8,
    parameter int ClkDivWidth = 8,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int IdWidth     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o,
    output logic                   sck_o,
    output logic                   mosi_o,
    output logic                   dc_o,
    output logic                   cs_no,
`ifdef USER_SPI_TX_RX_EN
    input  logic                   miso_i,
`endif
    output logic                   irq_o
);

    localparam int LvlW = $clog2(FifoDepth) + 1;
    localparam logic [ClkDivWidth-1:0] CNT_ONE = {{(ClkDivWidth-1){1'b0}}, 1'b1};

    // Handshake: every request is granted in the cycle it is raised
    // (gnt = req); its response (rvalid, rid, rdata, err) is presented for
    // exactly one cycle on the following clock.
    logic [2:0]             w_off;
    logic                   w_wr, w_rd, w_tx_wr, w_flush;
    logic                   w_full, w_empty, w_busy;
    logic [LvlW-1:0]        w_level;
    entry_t                 w_head;
    logic [DataWidth-1:0]   w_rdata;
    logic                   w_unused;

    logic                   r_rvalid, r_err, r_irq, r_irq_en;
    logic [DataWidth-1:0]   r_rdata;
    logic [IdWidth-1:0]     r_rid;
    logic [ClkDivWidth-1:0] r_clkdiv;

    state_t                 r_state, w_state_nxt;
    logic                   r_sck, r_mosi, r_dc, r_cs_n, r_last;
    logic                   w_sck_nxt, w_mosi_nxt, w_dc_nxt, w_cs_n_nxt, w_last_nxt;
    logic [7:0]             r_shreg, w_shreg_nxt;
    logic [2:0]             r_bit, w_bit_nxt;
    logic [ClkDivWidth-1:0] r_cnt, w_cnt_nxt;
    logic                   w_tick, w_pop, w_load;

    assign w_off    = addr_i[4:2];
    assign w_wr     = req_i & we_i;
    assign w_rd     = req_i & ~we_i;
    assign w_tx_wr  = w_wr & (w_off == OFF_TXDATA);
    assign w_flush  = w_wr & (w_off == OFF_CTRL) & wdata_i[1];
    assign w_busy   = (r_state != ST_IDLE);
    assign w_tick   = (r_cnt == '0);
    assign w_unused = ^{be_i, addr_i, wdata_i};

    assign gnt_o    = req_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign rid_o    = r_rid;
    assign err_o    = r_err;
    assign sck_o    = r_sck;
    assign mosi_o   = r_mosi;
    assign dc_o     = r_dc;
    assign cs_no    = r_cs_n;
    assign irq_o    = r_irq;

    user_spi_tx_fifo #(.Depth(FifoDepth)) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_flush (w_flush),
        .i_push  (w_tx_wr),
        .i_wdata (entry_t'(wdata_i[9:0])),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

`ifdef USER_SPI_TX_RX_EN
    logic [7:0] r_rx_sh, r_rxdata;
    logic       w_rise, w_gap_enter;

    // Rising SCK happens on the SETUP tick and on SHIFT ticks while SCK is low.
    assign w_rise      = w_tick & ((r_state == ST_SETUP) | ((r_state == ST_SHIFT) & ~r_sck));
    assign w_gap_enter = w_tick & (r_state == ST_SHIFT) & r_sck & (r_bit == 3'd7);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rx_sh  <= '0;
            r_rxdata <= '0;
        end else begin
            if (w_rise) begin
                r_rx_sh <= {r_rx_sh[6:0], miso_i};
            end
            if (w_gap_enter) begin
                r_rxdata <= r_rx_sh;
            end
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_STATUS: begin
                w_rdata[0]           = w_busy;
                w_rdata[1]           = w_full;
                w_rdata[2]           = w_empty;
                w_rdata[8 +: LvlW]   = w_level;
            end
            OFF_CLKDIV: w_rdata[ClkDivWidth-1:0] = r_clkdiv;
            OFF_CTRL:   w_rdata[0] = r_irq_en;
`ifdef USER_SPI_TX_RX_EN
            OFF_RXDATA: w_rdata[7:0] = r_rxdata;
`endif
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_err    <= 1'b0;
            r_clkdiv <= ClkDivWidth'(CLKDIV_RST);
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
            r_err    <= w_tx_wr & w_full;
            if (req_i) begin
                r_rid <= aid_i;
            end
            if (w_wr && (w_off == OFF_CLKDIV)) begin
                r_clkdiv <= wdata_i[ClkDivWidth-1:0];
            end
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_irq_en <= wdata_i[0];
            end
            r_irq <= r_irq_en & w_empty & ~w_busy;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_dc    <= 1'b0;
            r_cs_n  <= 1'b1;
            r_last  <= 1'b0;
            r_shreg <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_dc    <= w_dc_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_last  <= w_last_nxt;
            r_shreg <= w_shreg_nxt;
            r_bit   <= w_bit_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Serializer next state. r_cnt counts a half-period down to zero (tick)
    // and reloads from CLKDIV, so a divider write lands at the next reload.
    always_comb begin
        w_state_nxt = r_state;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_dc_nxt    = r_dc;
        w_cs_n_nxt  = r_cs_n;
        w_last_nxt  = r_last;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit;
        w_cnt_nxt   = w_tick ? r_clkdiv : (r_cnt - CNT_ONE);
        w_pop       = 1'b0;
        w_load      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load = ~w_empty;
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_sck_nxt   = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_sck) begin
                        w_sck_nxt = 1'b0;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            // Next bit goes out on the falling edge.
                            w_bit_nxt   = r_bit + 3'd1;
                            w_shreg_nxt = {r_shreg[6:0], 1'b0};
                            w_mosi_nxt  = r_shreg[6];
                        end
                    end else begin
                        w_sck_nxt = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_last) begin
                        w_cs_n_nxt  = 1'b1;
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Empty FIFO: stay here with CS low and re-check
                        // every half-period.
                        w_load = ~w_empty;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_load) begin
            w_pop       = 1'b1;
            w_cs_n_nxt  = 1'b0;
            w_dc_nxt    = w_head.dc;
            w_mosi_nxt  = w_head.data[7];
            w_shreg_nxt = w_head.data;
            w_last_nxt  = w_head.last;
            w_bit_nxt   = '0;
            w_cnt_nxt   = r_clkdiv;
            w_state_nxt = ST_SETUP;
        end

        if (w_flush) begin
            w_pop       = 1'b0;
            w_state_nxt = ST_IDLE;
            w_sck_nxt   = 1'b0;
            w_mosi_nxt  = 1'b0;
            w_cs_n_nxt  = 1'b1;
        end
    end

endmodule

// File: tb/tb_user_spi_tx_stream.sv
// Bench for user_spi_tx_stream: OBI driver, SPI line monitor that rebuilds
// each byte from MOSI sampled on rising SCK (frame end taken from CS), and
// an expected queue of {last, dc, byte} entries.
module tb_user_spi_tx_stream;

    logic        clk;
    logic        rst_n;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [0:0]  aid;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        sck, mosi, dc, cs_n, irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    int         cur_div = 3;
    int         m_bits = 0, m_run = 0, m_width_err = 0, m_glitch = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_prev_sck = 1'b0, m_prev_cs = 1'b1, m_prev_mosi = 1'b0;

`ifdef USER_SPI_TX_RX_EN
    logic       miso = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [2:0] rx_idx = 3'd7;
`endif

    user_spi_tx_stream dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .we_i     (we),
        .be_i     (be),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .aid_i    (aid),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .rid_o    (rid),
        .err_o    (err),
        .sck_o    (sck),
        .mosi_o   (mosi),
        .dc_o     (dc),
        .cs_no    (cs_n),
`ifdef USER_SPI_TX_RX_EN
        .miso_i   (miso),
`endif
        .irq_o    (irq)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0;
        addr = '0; wdata = '0; aid = '0;
    end

`ifdef USER_SPI_TX_RX_EN
    // Slave side: present the next MISO bit on every falling SCK.
    always @(negedge cs_n) begin
        rx_idx = 3'd7;
        miso   = rx_byte[7];
    end
    always @(negedge sck) begin
        if (cs_n === 1'b0) begin
            rx_idx = rx_idx - 3'd1;
            miso   = rx_byte[rx_idx];
        end
    end
`endif

    // SPI monitor: byte capture, half-period widths, MOSI stability while SCK high.
    always @(negedge clk) begin
        if (cs_n !== 1'b0) begin
            if (m_prev_cs === 1'b0 && got_q.size() > 0) got_q[got_q.size()-1][9] = 1'b1;
            m_bits = 0;
        end else begin
            if (sck === 1'b1 && m_prev_sck === 1'b0) begin
                if (m_bits != 0 && m_run != cur_div + 1) m_width_err++;
                m_byte = {m_byte[6:0], mosi};
                m_bits++;
                if (m_bits == 8) begin
                    got_q.push_back({1'b0, dc, m_byte});
                    m_bits = 0;
                end
            end else if (sck === 1'b0 && m_prev_sck === 1'b1) begin
                if (m_run != cur_div + 1) m_width_err++;
            end else if (sck === 1'b1 && m_prev_sck === 1'b1 && mosi !== m_prev_mosi) begin
                m_glitch++;
            end
        end
        if (sck !== m_prev_sck) m_run = 1;
        else m_run++;
        m_prev_sck  = sck;
        m_prev_cs   = cs_n;
        m_prev_mosi = mosi;
    end

    // Driver: one OBI transfer, returns the response.
    task automatic obi(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
        logic [0:0] id;
        @(negedge clk);
        id = 1'($urandom_range(0, 1));
        req = 1'b1; we = w; addr = a; wdata = d; aid = id; be = 4'hF;
        #1;
        n_checks++;
        if (gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL gnt addr=%h got=%b exp=1", a, gnt);
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rid !== id) begin
            n_errors++;
            $display("FAIL rsp addr=%h rvalid=%b rid=%b exp rvalid=1 rid=%b", a, rvalid, rid, id);
        end
        rd = rdata;
        e  = err;
    endtask

    // Wait until every expected byte has been seen and CS is released.
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(got_q.size() >= exp_q.size() && cs_n === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL wait_done timeout got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sck, mosi, dc, cs_n, irq, rvalid, err, rid} !== 8'b0001_0000 || rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs sck=%b mosi=%b dc=%b cs_n=%b irq=%b rvalid=%b err=%b rid=%b rdata=%h exp cs_n=1 rest 0",
                     sck, mosi, dc, cs_n, irq, rvalid, err, rid, rdata);
        end
        rst_n = 1'b1;
        obi(1'b0, 32'h4, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0000_0004 || e !== 1'b0) begin
            n_errors++; $display("FAIL reset_status got=%h err=%b exp=00000004", rd, e);
        end
        obi(1'b0, 32'h8, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h3) begin n_errors++; $display("FAIL reset_clkdiv got=%h exp=3", rd); end
        obi(1'b0, 32'hC, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
        obi(1'b0, 32'h14, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            n_errors++; $display("FAIL unmapped_14 got=%h err=%b exp=0", rd, e);
        end
`ifndef USER_SPI_TX_RX_EN
        obi(1'b0, 32'h10, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            n_errors++; $display("FAIL unmapped_10 got=%h err=%b exp=0", rd, e);
        end
`endif
    endtask

    task automatic test_single_byte();
        logic [31:0] rd;
        logic e;
        logic [9:0] g;
        obi(1'b1, 32'h8, 32'h0, rd, e);
        cur_div = 0;
        obi(1'b1, 32'h0, 32'h2A5, rd, e);
        exp_q.push_back(10'h2A5);
        wait_done(2000);
        n_checks++;
        if (got_q.size() != 1) begin
            n_errors++; $display("FAIL single_count got=%0d exp=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== 10'h2A5) begin n_errors++; $display("FAIL single_byte got=%h exp=2a5", g); end
        end
        exp_q.delete();
        got_q.delete();
        n_checks++;
        if (m_width_err != 0 || m_glitch != 0) begin
            n_errors++; $display("FAIL single_timing width_err=%0d glitch=%0d exp 0", m_width_err, m_glitch);
        end
    endtask

    task automatic test_frame();
        logic [31:0] rd;
        logic e;
        logic [9:0] g, x;
        logic [9:0] ents [3];
        ents[0] = 10'h1FF; ents[1] = 10'h100; ents[2] = 10'h3AA;
        obi(1'b1, 32'h8, 32'h1, rd, e);
        cur_div = 1;
        for (int k = 0; k < 3; k++) begin
            obi(1'b1, 32'h0, {22'b0, ents[k]}, rd, e);
            exp_q.push_back(ents[k]);
        end
        wait_done(3000);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_errors++; $display("FAIL frame_byte got=none exp=%h", x);
            end else begin
                g = got_q.pop_front();
                if (g !== x) begin n_errors++; $display("FAIL frame_byte got=%h exp=%h", g, x); end
            end
        end
        got_q.delete();
    endtask

    task automatic test_full();
        logic [31:0] rd;
        logic e;
        obi(1'b1, 32'h8, 32'hFF, rd, e);
        cur_div = 255;
        obi(1'b1, 32'h0, 32'h0AA, rd, e);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            obi(1'b1, 32'h0, {22'b0, 2'b00, 8'($urandom)}, rd, e);
            n_checks++;
            if (e !== (k == 8)) begin
                n_errors++; $display("FAIL full_err push=%0d got=%b exp=%b", k, e, (k == 8));
            end
        end
        obi(1'b0, 32'h4, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0000_0803) begin n_errors++; $display("FAIL full_status got=%h exp=00000803", rd); end
        obi(1'b1, 32'hC, 32'h2, rd, e);
        n_checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0 || e !== 1'b0) begin
            n_errors++; $display("FAIL full_flush cs_n=%b sck=%b err=%b exp 1 0 0", cs_n, sck, e);
        end
        obi(1'b0, 32'h4, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0000_0004) begin n_errors++; $display("FAIL full_status_flushed got=%h exp=00000004", rd); end
        obi(1'b0, 32'h8, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'hFF) begin n_errors++; $display("FAIL full_clkdiv_kept got=%h exp=ff", rd); end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_irq_flush();
        logic [31:0] rd;
        logic e;
        obi(1'b1, 32'h8, 32'h0, rd, e);
        cur_div = 0;
        obi(1'b1, 32'hC, 32'h1, rd, e);
        obi(1'b1, 32'h0, 32'h2C3, rd, e);
        exp_q.push_back(10'h2C3);
        repeat (4) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_busy got=%b exp=0", irq); end
        wait_done(2000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_idle got=%b exp=1", irq); end
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 10'h2C3) begin
            n_errors++; $display("FAIL irq_byte count=%0d exp 1 entry 2c3", got_q.size());
        end
        exp_q.delete();
        got_q.delete();
        // Flush in the middle of a byte.
        obi(1'b1, 32'h8, 32'h7, rd, e);
        cur_div = 7;
        obi(1'b1, 32'h0, 32'h055, rd, e);
        repeat (40) @(negedge clk);
        n_checks++;
        if (cs_n !== 1'b0) begin n_errors++; $display("FAIL flush_pre cs_n=%b exp=0", cs_n); end
        obi(1'b1, 32'hC, 32'h3, rd, e);
        n_checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0) begin
            n_errors++; $display("FAIL flush_lines cs_n=%b sck=%b exp 1 0", cs_n, sck);
        end
        obi(1'b0, 32'h4, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h0000_0004) begin n_errors++; $display("FAIL flush_status got=%h exp=00000004", rd); end
        obi(1'b0, 32'hC, 32'h0, rd, e);
        n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL flush_ctrl got=%h exp=1", rd); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL flush_irq got=%b exp=1", irq); end
        obi(1'b1, 32'hC, 32'h0, rd, e);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic e;
        logic [9:0] ent, g, x;
        int n;
        for (int b = 0; b < 4; b++) begin
            cur_div = $urandom_range(0, 3);
            obi(1'b1, 32'h8, 32'(cur_div), rd, e);
            n = $urandom_range(2, 6);
            for (int k = 0; k < n; k++) begin
                ent = 10'($urandom);
                ent[9] = (k == n - 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
                obi(1'b1, 32'h0, {22'b0, ent}, rd, e);
                n_checks++;
                if (e !== 1'b0) begin n_errors++; $display("FAIL rand_push_err got=%b exp=0", e); end
                exp_q.push_back(ent);
            end
            wait_done(20000);
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_checks++;
                if (got_q.size() == 0) begin
                    n_errors++; $display("FAIL rand_byte got=none exp=%h", x);
                end else begin
                    g = got_q.pop_front();
                    if (g !== x) begin n_errors++; $display("FAIL rand_byte got=%h exp=%h", g, x); end
                end
            end
            n_checks++;
            if (got_q.size() != 0) begin n_errors++; $display("FAIL rand_extra got=%0d exp=0", got_q.size()); end
            got_q.delete();
        end
        n_checks++;
        if (m_width_err != 0 || m_glitch != 0) begin
            n_errors++; $display("FAIL rand_timing width_err=%0d glitch=%0d exp 0", m_width_err, m_glitch);
        end
    endtask

`ifdef USER_SPI_TX_RX_EN
    task automatic test_rx();
        logic [31:0] rd;
        logic e;
        obi(1'b1, 32'h8, 32'h1, rd, e);
        cur_div = 1;
        for (int k = 0; k < 2; k++) begin
            rx_byte = (k == 0) ? 8'h3C : 8'($urandom);
            obi(1'b1, 32'h0, {22'b0, 2'b10, 8'($urandom)}, rd, e);
            exp_q.push_back(10'h0);
            wait_done(2000);
            obi(1'b0, 32'h10, 32'h0, rd, e);
            n_checks++;
            if (rd !== {24'b0, rx_byte}) begin
                n_errors++; $display("FAIL rxdata got=%h exp=%h", rd, {24'b0, rx_byte});
            end
            exp_q.delete();
            got_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_frame();
        test_full();
        test_irq_flush();
        test_random();
`ifdef USER_SPI_TX_RX_EN
        test_rx();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
